// File: rtl/key_schedule_buffer.sv
// Byte-serial key loader that cyclically expands a bcrypt password to a 72-byte key stream.
// Build option: define KEYBUF_NULL_TERM_EN to append a 0x00 terminator to keys shorter than 72 bytes.
//
// state  | meaning
// IDLE   | reset state, no key held
// LOAD   | accepting password bytes (in_ready=1)
// EXPAND | replicating stored bytes into positions len..71
// READY  | stream complete (key_loaded=1)
module key_schedule_buffer (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       in_end,
    input  logic [6:0] key_addr,
    output logic [7:0] key_data [8],
    output logic       key_loaded,
    output logic [6:0] key_len
);

    localparam int         MAX_KEY_BYTES = 72;
    localparam logic [6:0] KEY_MAX       = 7'(MAX_KEY_BYTES);
    localparam logic [6:0] KEY_LAST      = 7'(MAX_KEY_BYTES - 1);

`ifdef KEYBUF_NULL_TERM_EN
    localparam logic TERM_EN = 1'b1;
`else
    localparam logic TERM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

    state_t     state, state_nxt;
    logic [7:0] key_mem [MAX_KEY_BYTES];
    logic [6:0] len, len_nxt, len_acc;
    logic [6:0] e_ptr, e_nxt, s_ptr, s_nxt;
    logic       wr_en, term_wr;
    logic [6:0] wr_addr, term_addr;
    logic [7:0] wr_data;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        len_acc   = len;
        e_nxt     = e_ptr;
        s_nxt     = s_ptr;
        wr_en     = 1'b0;
        wr_addr   = len;
        wr_data   = in_byte;
        term_wr   = 1'b0;
        term_addr = len;
        if (load_start) begin
            state_nxt = LOAD;
            len_nxt   = 7'd0;
        end else begin
            case (state)
                LOAD: begin
                    // bytes past the 72nd are handshaken but not stored
                    if (in_valid && (len < KEY_MAX)) begin
                        wr_en   = 1'b1;
                        wr_addr = len;
                        wr_data = in_byte;
                        len_acc = len + 7'd1;
                    end
                    len_nxt = len_acc;
                    if (in_end) begin
                        if (TERM_EN && (len_acc < KEY_MAX)) begin
                            term_wr   = 1'b1;
                            term_addr = len_acc;
                            len_nxt   = len_acc + 7'd1;
                        end
                        e_nxt     = len_nxt;
                        s_nxt     = 7'd0;
                        state_nxt = (len_nxt < KEY_MAX) ? EXPAND : READY;
                    end
                end
                EXPAND: begin
                    // source positions are always below e_ptr, so they are already final
                    wr_en   = 1'b1;
                    wr_addr = e_ptr;
                    wr_data = (len == 7'd0) ? 8'h00 : key_mem[s_ptr];
                    e_nxt   = e_ptr + 7'd1;
                    s_nxt   = ((len == 7'd0) || (s_ptr + 7'd1 == len)) ? 7'd0 : s_ptr + 7'd1;
                    if (e_ptr == KEY_LAST) state_nxt = READY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            len   <= 7'd0;
            e_ptr <= 7'd0;
            s_ptr <= 7'd0;
            for (int i = 0; i < MAX_KEY_BYTES; i++) key_mem[i] <= 8'h00;
        end else begin
            len   <= len_nxt;
            e_ptr <= e_nxt;
            s_ptr <= s_nxt;
            for (int i = 0; i < MAX_KEY_BYTES; i++) begin
                if (wr_en && (wr_addr == 7'(i)))     key_mem[i] <= wr_data;
                if (term_wr && (term_addr == 7'(i))) key_mem[i] <= 8'h00;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        logic [7:0] idx;
        assign idx         = {1'b0, key_addr} + 8'(g);
        assign key_data[g] = (idx < 8'(MAX_KEY_BYTES)) ? key_mem[idx[6:0]] : 8'h00;
    end

    assign in_ready   = (state == LOAD);
    assign key_loaded = (state == READY);
    assign key_len    = len;

endmodule
